// File: rtl/de_stage_pkg.sv
// Shared decode definitions for the decode/execute boundary: opcodes, field ranges,
// instruction classification and immediate extension helpers.
package de_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_LUI, I_BEQ, I_JAL, I_JR
  } instr_e;

  // Anything not recognised collapses to I_NOP.
  function automatic instr_e classify(input logic [31:0] ir);
    instr_e kind;
    kind = I_NOP;
    case (ir[OP_HI:OP_LO])
      OP_RTYPE: begin
        case (ir[FN_HI:FN_LO])
          FN_ADDU: kind = I_ADDU;
          FN_SUBU: kind = I_SUBU;
          FN_JR:   kind = I_JR;
          default: kind = I_NOP;
        endcase
      end
      OP_ORI:  kind = I_ORI;
      OP_LW:   kind = I_LW;
      OP_SW:   kind = I_SW;
      OP_LUI:  kind = I_LUI;
      OP_BEQ:  kind = I_BEQ;
      OP_JAL:  kind = I_JAL;
      default: kind = I_NOP;
    endcase
    return kind;
  endfunction

  function automatic logic [31:0] ext_imm(input logic [31:0] ir);
    logic [15:0] imm;
    logic [31:0] ext;
    imm = ir[IMM_HI:IMM_LO];
    case (classify(ir))
      I_ORI:             ext = {16'h0000, imm};
      I_LW, I_SW, I_BEQ: ext = {{16{imm[15]}}, imm};
      I_LUI:             ext = {imm, 16'h0000};
      default:           ext = 32'h0000_0000;
    endcase
    return ext;
  endfunction

  // Register 0 is never a producer, so it never matches.
  function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src,
                                   input logic used);
    return used && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/de_stage_instr_class.sv
// Per-instruction classification: destination register and operand-use flags.
module instr_class
  import de_stage_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  dest,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_lw,
  output logic        is_branch_d
);

  instr_e kind;
  assign kind = classify(ir);

  always_comb begin
    dest        = 5'd0;
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    is_lw       = 1'b0;
    is_branch_d = 1'b0;
    case (kind)
      I_ADDU, I_SUBU: begin
        dest    = ir[RD_HI:RD_LO];
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      I_ORI: begin
        dest    = ir[RT_HI:RT_LO];
        uses_rs = 1'b1;
      end
      I_LW: begin
        dest    = ir[RT_HI:RT_LO];
        uses_rs = 1'b1;
        is_lw   = 1'b1;
      end
      I_SW: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      I_LUI: dest = ir[RT_HI:RT_LO];
      I_BEQ: begin
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        is_branch_d = 1'b1;
      end
      I_JAL: dest = REG_RA;
      I_JR: begin
        uses_rs     = 1'b1;
        is_branch_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/de_stage.sv
// Decode stage: operand forwarding, hazard stall detection and the D/E pipeline register.
module de_stage
  import de_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic [31:0] pc4_d,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic [31:0] ir_m,
  input  logic [31:0] fwd_m,
  input  logic [31:0] ir_w,
  input  logic [31:0] wdata,
  input  logic [4:0]  wreg,
  output logic [31:0] ir_e,
  output logic [31:0] pc4_e,
  output logic [31:0] rs_e,
  output logic [31:0] rt_e,
  output logic [31:0] ext_e,
  output logic        stall,
  output logic [31:0] rs_d,
  output logic [31:0] rt_d
);

  localparam int NS = 4;
  localparam int SD = 0;
  localparam int SE = 1;
  localparam int SM = 2;
  localparam int SW = 3;

  logic [31:0] ir_e_reg, pc4_e_reg, rs_e_reg, rt_e_reg, ext_e_reg;

  logic [31:0] ir_all [NS];
  logic [4:0]  dest_all [NS];
  logic [NS-1:0] uses_rs_v, uses_rt_v, is_lw_v, is_br_v;

  assign ir_all[SD] = ir_d;
  assign ir_all[SE] = ir_e_reg;
  assign ir_all[SM] = ir_m;
  assign ir_all[SW] = ir_w;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_cls
      instr_class u_cls (
        .ir          (ir_all[gi]),
        .dest        (dest_all[gi]),
        .uses_rs     (uses_rs_v[gi]),
        .uses_rt     (uses_rt_v[gi]),
        .is_lw       (is_lw_v[gi]),
        .is_branch_d (is_br_v[gi])
      );
    end
  endgenerate

  // The W destination comes from decoding ir_w; wreg is carried only for completeness.
  logic unused_sink;
  assign unused_sink = ^{wreg, uses_rs_v, uses_rt_v, is_lw_v, is_br_v};

  logic [4:0] rs_f, rt_f;
  assign rs_f = ir_d[RS_HI:RS_LO];
  assign rt_f = ir_d[RT_HI:RT_LO];

  logic e_hit, m_hit;
  assign e_hit = reg_hit(dest_all[SE], rs_f, uses_rs_v[SD]) ||
                 reg_hit(dest_all[SE], rt_f, uses_rt_v[SD]);
  assign m_hit = reg_hit(dest_all[SM], rs_f, uses_rs_v[SD]) ||
                 reg_hit(dest_all[SM], rt_f, uses_rt_v[SD]);

  always_comb begin
    stall = 1'b0;
    if (is_lw_v[SE] && e_hit)
      stall = 1'b1;
    if (is_br_v[SD] && e_hit)
      stall = 1'b1;
    if (is_br_v[SD] && is_lw_v[SM] && m_hit)
      stall = 1'b1;
  end

  // A loaded value is not available in M, so lw results only come through W.
  always_comb begin
    rs_d = rf_rd1;
    if (reg_hit(dest_all[SM], rs_f, 1'b1) && !is_lw_v[SM])
      rs_d = fwd_m;
    else if (reg_hit(dest_all[SW], rs_f, 1'b1))
      rs_d = wdata;
  end

  always_comb begin
    rt_d = rf_rd2;
    if (reg_hit(dest_all[SM], rt_f, 1'b1) && !is_lw_v[SM])
      rt_d = fwd_m;
    else if (reg_hit(dest_all[SW], rt_f, 1'b1))
      rt_d = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_e_reg  <= '0;
      pc4_e_reg <= '0;
      rs_e_reg  <= '0;
      rt_e_reg  <= '0;
      ext_e_reg <= '0;
    end else if (stall) begin
      ir_e_reg  <= '0;
      pc4_e_reg <= '0;
      rs_e_reg  <= '0;
      rt_e_reg  <= '0;
      ext_e_reg <= '0;
    end else begin
      ir_e_reg  <= ir_d;
      pc4_e_reg <= pc4_d;
      rs_e_reg  <= rs_d;
      rt_e_reg  <= rt_d;
      ext_e_reg <= ext_imm(ir_d);
    end
  end

  assign ir_e  = ir_e_reg;
  assign pc4_e = pc4_e_reg;
  assign rs_e  = rs_e_reg;
  assign rt_e  = rt_e_reg;
  assign ext_e = ext_e_reg;

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: stimulus pushes hand-computed expectations, a monitor pops and checks.
module tb_de_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir_d = '0, pc4_d = '0, rf_rd1 = '0, rf_rd2 = '0;
  logic [31:0] ir_m = '0, fwd_m = '0, ir_w = '0, wdata = '0;
  logic [4:0]  wreg = '0;
  logic [31:0] ir_e, pc4_e, rs_e, rt_e, ext_e, rs_d, rt_d;
  logic        stall;

  de_stage dut (
    .clk(clk), .reset(reset),
    .ir_d(ir_d), .pc4_d(pc4_d), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ir_m(ir_m), .fwd_m(fwd_m), .ir_w(ir_w), .wdata(wdata), .wreg(wreg),
    .ir_e(ir_e), .pc4_e(pc4_e), .rs_e(rs_e), .rt_e(rt_e), .ext_e(ext_e),
    .stall(stall), .rs_d(rs_d), .rt_d(rt_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] rs_d, rt_d, ir_e, pc4_e, rs_e, rt_e, ext_e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  event sample_ev;

  always @(negedge clk) ->sample_ev;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%08h required=%08h", name, field, act, exp);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(sample_ev);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk(x.name, "stall", {31'd0, stall}, {31'd0, x.stall});
        chk(x.name, "rs_d",  rs_d,  x.rs_d);
        chk(x.name, "rt_d",  rt_d,  x.rt_d);
        chk(x.name, "ir_e",  ir_e,  x.ir_e);
        chk(x.name, "pc4_e", pc4_e, x.pc4_e);
        chk(x.name, "rs_e",  rs_e,  x.rs_e);
        chk(x.name, "rt_e",  rt_e,  x.rt_e);
        chk(x.name, "ext_e", ext_e, x.ext_e);
        $display("txn %-12s stall=%0b rs_d=%08h rt_d=%08h ir_e=%08h ext_e=%08h",
                 x.name, stall, rs_d, rt_d, ir_e, ext_e);
      end
    end
  end

  task automatic drive(input logic rst, input logic [31:0] d, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] m, input logic [31:0] fm,
                       input logic [31:0] w, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset  = rst;
    ir_d   = d;  pc4_d = p;  rf_rd1 = r1; rf_rd2 = r2;
    ir_m   = m;  fwd_m = fm; ir_w   = w;  wdata  = wd;
    wreg   = w[15:11];
  endtask

  task automatic expect_(input string name, input logic st,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] ie, input logic [31:0] pe,
                         input logic [31:0] rse, input logic [31:0] rte,
                         input logic [31:0] ee);
    exp_t x;
    x.name = name; x.stall = st; x.rs_d = rsd; x.rt_d = rtd;
    x.ir_e = ie; x.pc4_e = pe; x.rs_e = rse; x.rt_e = rte; x.ext_e = ee;
    q.push_back(x);
  endtask

  localparam logic [31:0] LW8     = 32'h8C08_0000; // lw $8,0($0)
  localparam logic [31:0] ADDU988 = 32'h0108_4821; // addu $9,$8,$8
  localparam logic [31:0] ORI5    = 32'h3405_1234; // ori $5,$0,0x1234
  localparam logic [31:0] BEQ55   = 32'h10A5_0000; // beq $5,$5,0
  localparam logic [31:0] ADDU3   = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] JR3     = 32'h0060_0008; // jr $3
  localparam logic [31:0] ORI3    = 32'h3403_0055; // ori $3,$0,0x55
  localparam logic [31:0] LUI4    = 32'h3C04_ABCD; // lui $4,0xABCD
  localparam logic [31:0] BEQ40   = 32'h1080_0000; // beq $4,$0,0
  localparam logic [31:0] ADDU0   = 32'h0022_0021; // addu $0,$1,$2
  localparam logic [31:0] ADDU100 = 32'h0000_0821; // addu $1,$0,$0
  localparam logic [31:0] ORI8000 = 32'h3401_8000; // ori $1,$0,0x8000
  localparam logic [31:0] BEQ80   = 32'h1100_0000; // beq $8,$0,0
  localparam logic [31:0] SWNEG   = 32'hAC22_FFFC; // sw $2,-4($1)

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, ORI8000, 32'h100, 32'h11, 32'h22, 0, 0, 0, 0);
    expect_("reset_hold", 0, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    @(negedge clk); #1 reset = 1'b1;

    drive(1'b1, LW8, 32'h104, 32'h0, 32'h55, 0, 0, 0, 0);
    expect_("ori_ext", 0, 32'h0, 32'h55, ORI8000, 32'h100, 32'h11, 32'h22, 32'h0000_8000);

    drive(1'b1, ADDU988, 32'h108, 32'h77, 32'h77, 0, 0, 0, 0);
    expect_("load_use", 1, 32'h77, 32'h77, LW8, 32'h104, 32'h0, 32'h55, 32'h0);

    drive(1'b1, ADDU988, 32'h108, 32'h77, 32'h77, LW8, 32'h999, 0, 0);
    expect_("bubble", 0, 32'h77, 32'h77, 0, 0, 0, 0, 0);

    drive(1'b1, BEQ55, 32'h10C, 32'h0, 32'h0, ORI5, 32'h1234, 0, 0);
    expect_("m_fwd", 0, 32'h1234, 32'h1234, ADDU988, 32'h108, 32'h77, 32'h77, 32'h0);

    drive(1'b1, JR3, 32'h110, 32'h1, 32'h2, 0, 0, ADDU3, 32'hDEAD_BEEF);
    expect_("w_fwd", 0, 32'hDEAD_BEEF, 32'h2, BEQ55, 32'h10C, 32'h1234, 32'h1234, 32'h0);

    drive(1'b1, JR3, 32'h110, 32'h1, 32'h2, ORI3, 32'hCAFE_0000, ADDU3, 32'hDEAD_BEEF);
    expect_("m_over_w", 0, 32'hCAFE_0000, 32'h2, JR3, 32'h110, 32'hDEAD_BEEF, 32'h2, 32'h0);

    drive(1'b1, LUI4, 32'h114, 32'h3, 32'h4, 0, 0, 0, 0);
    expect_("lui_issue", 0, 32'h3, 32'h4, JR3, 32'h110, 32'hCAFE_0000, 32'h2, 32'h0);

    drive(1'b1, BEQ40, 32'h118, 32'h5, 32'h6, 0, 0, 0, 0);
    expect_("br_haz_e", 1, 32'h5, 32'h6, LUI4, 32'h114, 32'h3, 32'h4, 32'hABCD_0000);

    drive(1'b1, ADDU100, 32'h11C, 32'h9, 32'hA, ADDU0, 32'h7, 0, 0);
    expect_("reg0", 0, 32'h9, 32'hA, 0, 0, 0, 0, 0);

    drive(1'b1, BEQ80, 32'h120, 32'hB, 32'hC, LW8, 32'h0, 0, 0);
    expect_("br_haz_mlw", 1, 32'hB, 32'hC, ADDU100, 32'h11C, 32'h9, 32'hA, 32'h0);

    drive(1'b1, SWNEG, 32'h124, 32'h10, 32'h20, 0, 0, 0, 0);
    expect_("sw_issue", 0, 32'h10, 32'h20, 0, 0, 0, 0, 0);

    drive(1'b1, 32'h0, 32'h128, 32'h0, 32'h0, 0, 0, 0, 0);
    expect_("sext", 0, 32'h0, 32'h0, SWNEG, 32'h124, 32'h10, 32'h20, 32'hFFFF_FFFC);

    drive(1'b1, LW8, 32'h12C, 32'h0, 32'h0, 0, 0, 0, 0);
    expect_("nop_e", 0, 32'h0, 32'h0, 0, 32'h128, 0, 0, 0);

    drive(1'b1, ADDU988, 32'h130, 32'h44, 32'h44, 0, 0, 0, 0);
    expect_("stall_again", 1, 32'h44, 32'h44, LW8, 32'h12C, 32'h0, 32'h0, 32'h0);

    @(negedge clk); #1 reset = 1'b0;
    expect_("async_rst", 0, 32'h44, 32'h44, 0, 0, 0, 0, 0);
    #1 ->sample_ev;

    drive(1'b1, ORI8000, 32'h200, 32'h31, 32'h32, 0, 0, 0, 0);
    expect_("post_rst", 0, 32'h31, 32'h32, 0, 0, 0, 0, 0);

    drive(1'b1, 32'h0, 32'h204, 32'h0, 32'h0, 0, 0, 0, 0);
    expect_("resume", 0, 32'h0, 32'h0, ORI8000, 32'h200, 32'h31, 32'h32, 32'h0000_8000);

    repeat (3) @(negedge clk);
    #1;
    chk("drain", "queue_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
